// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pwm_pkg
// Purpose  : Shared types and constants for the 8-bit PWM generator and the
//            PWM capture block.
// Contents : state_e       capture FSM states
//            DUTY_W        duty code width (0..255 scale)
//            CNT_W_DEFAULT default width of the capture counters
// Revision : 1.0  initial release
// ============================================================================
package pwm_pkg;

    localparam int DUTY_W        = 8;
    localparam int CNT_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_e;

endpackage : pwm_pkg
`default_nettype wire

// File: rtl/pwm_div.sv
`default_nettype none
// ============================================================================
// Module   : pwm_div
// Purpose  : Serial restoring divider producing floor(hi*2^DUTY_W/period),
//            one quotient bit per cycle. Requires hi <= period.
// Ports    : clk_i       system clock
//            rst_n_i     asynchronous active-low reset
//            start_i     load operands (ignored while busy_o)
//            hi_i        dividend (high time)
//            period_i    divisor (period)
//            busy_o      high from the cycle after start until one cycle
//                        after done_o
//            done_o      high during the final iteration cycle
//            quotient_o  final quotient, valid while done_o is high
// Revision : 1.0  initial release
// ============================================================================
module pwm_div
    import pwm_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic [CNT_W-1:0]  hi_i,
    input  logic [CNT_W-1:0]  period_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DUTY_W-1:0] quotient_o
);

    localparam int               STEP_W    = $clog2(DUTY_W + 1);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(DUTY_W - 1);
    localparam logic [STEP_W-1:0] TAIL_STEP = STEP_W'(DUTY_W);

    logic [CNT_W:0]      rem_q;
    logic [CNT_W-1:0]    div_q;
    logic [DUTY_W-1:0]   quo_q;
    logic [STEP_W-1:0]   step_q;
    logic                busy_q;

    logic [CNT_W:0]      w_rem_sh;
    logic                w_qbit;
    logic [CNT_W:0]      rem_d;
    logic [DUTY_W-1:0]   quo_d;

    // The remainder is always below the divisor on entry to a step, so its
    // MSB is zero and the shift cannot lose information.
    assign w_rem_sh = rem_q << 1;
    assign w_qbit   = (w_rem_sh >= {1'b0, div_q});
    assign rem_d    = w_qbit ? (w_rem_sh - {1'b0, div_q}) : w_rem_sh;
    assign quo_d    = {quo_q[DUTY_W-2:0], w_qbit};

    // The quotient is handed out combinationally in the last iteration so
    // the consumer can register it on the same edge that finishes the divide.
    assign quotient_o = quo_d;
    assign done_o     = busy_q && (step_q == LAST_STEP);
    assign busy_o     = busy_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rem_q  <= '0;
            div_q  <= '0;
            quo_q  <= '0;
            step_q <= '0;
            busy_q <= 1'b0;
        end else if (start_i && !busy_q) begin
            rem_q  <= {1'b0, hi_i};
            div_q  <= period_i;
            quo_q  <= '0;
            step_q <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            // One tail cycle after the last step keeps busy asserted while the
            // result is being presented downstream.
            if (step_q == TAIL_STEP) begin
                busy_q <= 1'b0;
            end else begin
                rem_q  <= rem_d;
                quo_q  <= quo_d;
                step_q <= step_q + 1'b1;
            end
        end
    end

endmodule : pwm_div
`default_nettype wire

// File: rtl/pwm_capture.sv
`default_nettype none
// ============================================================================
// Module   : pwm_capture
// Purpose  : Measures high time and rise-to-rise period of an asynchronous
//            PWM input and reports an 8-bit duty code, a stuck-input flag and
//            a sticky overrun flag.
// Ports    : clk_i         system clock
//            rst_n_i       asynchronous active-low reset
//            ena_i         capture enable
//            pwm_in_i      asynchronous PWM input
//            high_cnt_o    high time of last completed period (clk cycles)
//            period_cnt_o  rise-to-rise period of last completed period
//            duty_o        floor(high_cnt*256/period_cnt)
//            valid_o       one-cycle pulse when results update
//            stuck_o       no edge seen within the saturation count
//            stuck_lvl_o   synchronized input level when stuck was set
//            overrun_o     sticky: a period completed while dividing
// Revision : 1.0  initial release
// ============================================================================
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              ena_i,
    input  logic              pwm_in_i,
    output logic [CNT_W-1:0]  high_cnt_o,
    output logic [CNT_W-1:0]  period_cnt_o,
    output logic [DUTY_W-1:0] duty_o,
    output logic              valid_o,
    output logic              stuck_o,
    output logic              stuck_lvl_o,
    output logic              overrun_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_d_q;
    state_e                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       hi_len_q;
    logic [CNT_W-1:0]       pend_hi_q;
    logic [CNT_W-1:0]       pend_per_q;
    logic [CNT_W-1:0]       high_cnt_q;
    logic [CNT_W-1:0]       period_cnt_q;
    logic [DUTY_W-1:0]      duty_q;
    logic                   valid_q;
    logic                   stuck_q;
    logic                   stuck_lvl_q;
    logic                   overrun_q;

    logic                   w_s;
    logic                   w_rise;
    logic                   w_fall;
    logic                   w_sat;
    logic                   w_edge;
    logic                   w_timeout;
    logic                   w_period_done;
    logic [CNT_W-1:0]       cnt_d;
    logic                   w_div_busy;
    logic                   w_div_done;
    logic [DUTY_W-1:0]      w_div_quo;

    // ------------------------------------------------------------------
    // Input synchronizer and edge detection
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= '0;
            s_d_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in_i};
            s_d_q  <= w_s;
        end
    end

    assign w_s    = sync_q[SYNC_STAGES-1];
    assign w_rise = w_s & ~s_d_q;
    assign w_fall = ~w_s & s_d_q;

    // ------------------------------------------------------------------
    // Event decode
    // ------------------------------------------------------------------
    assign w_sat = (cnt_q == CNT_MAX);
    assign cnt_d = w_sat ? cnt_q : (cnt_q + 1'b1);

    // The edge that would advance the FSM in its current state; it takes
    // priority over saturation in the same cycle.
    assign w_edge = (state_q == HIGH) ? w_fall : w_rise;

    // Stuck only fires once; while stuck the FSM idles at a saturated count.
    assign w_timeout     = ena_i && w_sat && !w_edge && !stuck_q;
    assign w_period_done = ena_i && (state_q == LOW) && w_rise;

    // ------------------------------------------------------------------
    // Divider
    // ------------------------------------------------------------------
    pwm_div #(
        .CNT_W (CNT_W)
    ) u_div (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .start_i    (w_period_done),
        .hi_i       (hi_len_q),
        .period_i   (cnt_q),
        .busy_o     (w_div_busy),
        .done_o     (w_div_done),
        .quotient_o (w_div_quo)
    );

    // ------------------------------------------------------------------
    // FSM, counter and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            hi_len_q     <= '0;
            pend_hi_q    <= '0;
            pend_per_q   <= '0;
            high_cnt_q   <= '0;
            period_cnt_q <= '0;
            duty_q       <= '0;
            valid_q      <= 1'b0;
            stuck_q      <= 1'b0;
            stuck_lvl_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;

            // A period ending while the previous divide runs is discarded.
            if (w_period_done && w_div_busy) begin
                overrun_q <= 1'b1;
            end

            // A divide started before ena fell still finishes internally, but
            // its result is only published while capture is enabled.
            if (w_div_done && ena_i) begin
                high_cnt_q   <= pend_hi_q;
                period_cnt_q <= pend_per_q;
                duty_q       <= w_div_quo;
                valid_q      <= 1'b1;
            end

            if (!ena_i) begin
                state_q <= IDLE;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_d;

                case (state_q)
                    IDLE: begin
                        if (w_rise) begin
                            state_q <= HIGH;
                            cnt_q   <= CNT_ONE;
                            stuck_q <= 1'b0;
                        end
                    end
                    HIGH: begin
                        if (w_fall) begin
                            hi_len_q <= cnt_q;
                            state_q  <= LOW;
                        end
                    end
                    LOW: begin
                        if (w_rise) begin
                            if (!w_div_busy) begin
                                pend_hi_q  <= hi_len_q;
                                pend_per_q <= cnt_q;
                            end
                            cnt_q   <= CNT_ONE;
                            state_q <= HIGH;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase

                if (w_timeout) begin
                    state_q      <= IDLE;
                    stuck_q      <= 1'b1;
                    stuck_lvl_q  <= w_s;
                    duty_q       <= w_s ? {DUTY_W{1'b1}} : {DUTY_W{1'b0}};
                    high_cnt_q   <= '0;
                    period_cnt_q <= '0;
                    valid_q      <= 1'b1;
                end
            end
        end
    end

    assign high_cnt_o   = high_cnt_q;
    assign period_cnt_o = period_cnt_q;
    assign duty_o       = duty_q;
    assign valid_o      = valid_q;
    assign stuck_o      = stuck_q;
    assign stuck_lvl_o  = stuck_lvl_q;
    assign overrun_o    = overrun_q;

endmodule : pwm_capture
`default_nettype wire

// File: tb/tb_pwm_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_capture
// Purpose  : Self-checking bench for pwm_capture. The driver produces a PWM
//            waveform as (high, low) segments and predicts each completed
//            period from the edge times it generated; a monitor pops the
//            predictions whenever the DUT pulses valid.
// Revision : 1.0  initial release
// ============================================================================
module tb_pwm_capture;

    localparam int CNT_W = 10;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             ena   = 1'b0;
    logic             pwm   = 1'b0;
    logic [CNT_W-1:0] high_cnt;
    logic [CNT_W-1:0] period_cnt;
    logic [7:0]       duty;
    logic             valid;
    logic             stuck;
    logic             stuck_lvl;
    logic             overrun;

    pwm_capture #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (2)
    ) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .ena_i        (ena),
        .pwm_in_i     (pwm),
        .high_cnt_o   (high_cnt),
        .period_cnt_o (period_cnt),
        .duty_o       (duty),
        .valid_o      (valid),
        .stuck_o      (stuck),
        .stuck_lvl_o  (stuck_lvl),
        .overrun_o    (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int hi;
        int per;
        int duty;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model state, in input-cycle time
    int   cyc          = 0;
    bit   meas_active  = 1'b0;
    int   last_rise    = 0;
    int   last_fall    = 0;
    bit   have_start   = 1'b0;
    int   last_start   = 0;
    bit   exp_overrun  = 1'b0;
    bit   exp_stuck    = 1'b0;
    bit   exp_stuck_lvl = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Model: a rise closes the running period (if any) and opens a new one.
    task automatic on_rise();
        exp_t e;
        exp_stuck = 1'b0;
        if (meas_active) begin
            e.hi   = last_fall - last_rise;
            e.per  = cyc - last_rise;
            e.duty = (e.hi * 256) / e.per;
            if (have_start && (cyc - last_start) < 10) begin
                exp_overrun = 1'b1;
            end else begin
                q.push_back(e);
                have_start = 1'b1;
                last_start = cyc;
            end
        end
        meas_active = 1'b1;
        last_rise   = cyc;
    endtask

    task automatic step_pwm(input bit v);
        exp_t e;
        @(negedge clk);
        if (ena && v && !pwm) on_rise();
        if (!v && pwm) last_fall = cyc;
        pwm = v;
        cyc++;
        // No edge for a full counter range: stuck with a single report.
        if (ena && meas_active && !exp_stuck && (cyc - last_rise) >= MAXC) begin
            e.hi          = 0;
            e.per         = 0;
            e.duty        = v ? 255 : 0;
            q.push_back(e);
            exp_stuck     = 1'b1;
            exp_stuck_lvl = v;
            meas_active   = 1'b0;
        end
    endtask

    task automatic level(input bit v, input int n);
        for (int i = 0; i < n; i++) step_pwm(v);
    endtask

    task automatic seg(input int h, input int l);
        level(1'b1, h);
        level(1'b0, l);
    endtask

    task automatic check_status(input string tag);
        check({tag, "_overrun"}, int'(overrun), int'(exp_overrun));
        check({tag, "_stuck"}, int'(stuck), int'(exp_stuck));
        if (exp_stuck) check({tag, "_stuck_lvl"}, int'(stuck_lvl), int'(exp_stuck_lvl));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_high_cnt"}, int'(high_cnt), 0);
        check({tag, "_period_cnt"}, int'(period_cnt), 0);
        check({tag, "_duty"}, int'(duty), 0);
        check({tag, "_valid"}, int'(valid), 0);
        check({tag, "_stuck"}, int'(stuck), 0);
        check({tag, "_stuck_lvl"}, int'(stuck_lvl), 0);
        check({tag, "_overrun"}, int'(overrun), 0);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic reset_pulse(input string tag);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero(tag);
        pwm         = 1'b0;
        q.delete();
        meas_active = 1'b0;
        have_start  = 1'b0;
        exp_overrun = 1'b0;
        exp_stuck   = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: every valid pulse must match the oldest prediction.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && valid) begin
            if (q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_valid: got high=%0d period=%0d duty=%0d, expected no result (t=%0t)",
                         high_cnt, period_cnt, duty, $time);
            end else begin
                e = q.pop_front();
                check("high_cnt", int'(high_cnt), e.hi);
                check("period_cnt", int'(period_cnt), e.per);
                check("duty", int'(duty), e.duty);
            end
        end
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        ena   = 1'b0;
        pwm   = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        ena   = 1'b1;

        // Generator duty codes 64, 1 and the H=255/L=1 extreme
        repeat (4) seg(64, 192);
        check_status("dc64");
        repeat (3) seg(1, 255);
        repeat (3) seg(255, 1);
        check_status("dc_extremes");

        // Random clean periods (all >= 10 cycles)
        repeat (40) seg($urandom_range(5, 120), $urandom_range(5, 120));
        check_status("random_clean");

        // Minimum clean period, then overrun, then sticky after recovery
        repeat (10) seg(3, 7);
        check_status("period10");
        repeat (6) seg(2, 2);
        level(1'b0, 10);
        check_status("overrun_set");
        repeat (5) seg(3, 7);
        check_status("overrun_sticky");

        // Stuck high after one rise; next rise clears it
        level(1'b0, 20);
        level(1'b1, 1100);
        check_status("stuck_high");
        check("stuck_duty", int'(duty), 255);
        level(1'b0, 30);
        level(1'b1, 10);
        check_status("stuck_cleared");
        level(1'b0, 100);
        repeat (2) seg(64, 192);

        // Reset mid-HIGH, then reset mid-divide
        level(1'b1, 30);
        reset_pulse("rst_mid_high");
        repeat (3) seg(64, 192);
        check_status("after_rst_high");
        level(1'b1, 5);
        reset_pulse("rst_mid_div");
        repeat (3) seg(64, 192);
        check_status("after_rst_div");

        // Enable dropped for 50 cycles mid-LOW
        level(1'b1, 64);
        level(1'b0, 40);
        ena         = 1'b0;
        meas_active = 1'b0;
        level(1'b0, 50);
        ena = 1'b1;
        level(1'b0, 40);
        repeat (3) seg(64, 192);
        check_status("after_ena");

        // Random mix including periods short enough to overrun
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 2) == 0) seg($urandom_range(1, 6), $urandom_range(1, 6));
            else                           seg($urandom_range(1, 80), $urandom_range(1, 80));
        end
        level(1'b0, 40);
        check_status("random_mix");

        check("drain_pending", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_pwm_capture
`default_nettype wire
